// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls an NES controller over latch/clock/data and presents
// the decoded, active-high button byte with a one-cycle valid pulse.
module nes_pad_reader #(
  parameter int CLK_DIV    = 300,
  parameter int POLL_TICKS = 2778
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid
);
  localparam logic [2:0] IDLE = 3'd0, LATCH = 3'd1, LOW = 3'd2, HIGH = 3'd3, DONE = 3'd4;
  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = ($clog2(POLL_TICKS + 1) > 16) ? $clog2(POLL_TICKS + 1) : 16;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] POLL = IW'(POLL_TICKS);
  logic [2:0] state, i;
  logic [DW-1:0] div;
  logic [IW-1:0] ivl;
  logic [7:0] sr, sr_n;
  logic s1, s2, tick;
  assign tick = div == DIV_MAX;
  always_comb begin
    sr_n = sr;
    sr_n[i] = s2;
  end
  // A poll fires on the tick that completes the POLL_TICKS-th idle tick, or on
  // the first tick after enable returns once the interval has saturated.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      i <= '0;
      div <= '0;
      ivl <= '0;
      sr <= '0;
      s1 <= 1'b1;
      s2 <= 1'b1;
      pad_latch <= 1'b0;
      pad_clk <= 1'b0;
      buttons <= '0;
      buttons_valid <= 1'b0;
    end else begin
      {s2, s1} <= {s1, pad_data};
      div <= tick ? '0 : div + 1'b1;
      buttons_valid <= 1'b0;
      if (state == DONE) begin
        state <= IDLE;
        ivl <= '0;
      end else if (tick)
        case (state)
          IDLE:
            if (enable && ivl >= POLL - 1'b1) begin
              ivl <= '0;
              i <= '0;
              state <= LATCH;
              pad_latch <= 1'b1;
            end else if (ivl != POLL) ivl <= ivl + 1'b1;
          LATCH:
            if (i == 3'd1) begin
              i <= '0;
              state <= LOW;
              pad_latch <= 1'b0;
            end else i <= i + 3'd1;
          LOW: begin
            sr <= sr_n;
            if (i == 3'd7) begin
              state <= DONE;
              buttons <= ~sr_n;
              buttons_valid <= 1'b1;
            end else begin
              state <= HIGH;
              pad_clk <= 1'b1;
            end
          end
          HIGH: begin
            state <= LOW;
            pad_clk <= 1'b0;
            i <= i + 3'd1;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: directed vectors through a serial pad model plus
// enable-drop and mid-transaction reset sequences.
module tb_nes_pad_reader;
  logic clk = 0, reset, enable;
  logic pad_data, pad_latch, pad_clk, buttons_valid;
  logic [7:0] buttons, pat;
  nes_pad_reader #(.CLK_DIV(4), .POLL_TICKS(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons), .buttons_valid(buttons_valid)
  );
  always #5 clk = ~clk;
  int idx = 8;
  always @(posedge pad_latch) idx = 0;
  always @(posedge pad_clk) idx++;
  assign pad_data = (idx < 8) ? ~pat[idx] : 1'b1;
  int cyc = 0, lat_rise = 0, prev_rise = 0, lat_count = 0, lat_hi = 0, lat_w = 0;
  int clk_pulses = 0, clk_hi = 0, clk_bad = 0, val_count = 0, val_cyc = 0, val_hi = 0, val_w = 0;
  int both_hi = 0, partial = 0;
  logic l_q = 0, c_q = 0, v_q = 0;
  logic [7:0] b_q = 0;
  always @(negedge clk) begin
    cyc++;
    if (pad_latch && !l_q) begin prev_rise = lat_rise; lat_rise = cyc; lat_count++; lat_hi = 0; clk_pulses = 0; clk_bad = 0; end
    if (pad_latch) lat_hi++;
    if (!pad_latch && l_q) lat_w = lat_hi;
    if (pad_clk && !c_q) begin clk_pulses++; clk_hi = 0; end
    if (pad_clk) clk_hi++;
    if (!pad_clk && c_q && clk_hi != 4) clk_bad++;
    if (buttons_valid && !v_q) begin val_count++; val_cyc = cyc; val_hi = 0; end
    if (buttons_valid) val_hi++;
    if (!buttons_valid && v_q) val_w = val_hi;
    if (pad_latch && pad_clk) both_hi++;
    if (!reset && !buttons_valid && buttons != b_q) partial++;
    l_q = pad_latch; c_q = pad_clk; v_q = buttons_valid; b_q = buttons;
  end
  int nvec = 0, nfail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic wait_lat(input string nm);
    int n0 = lat_count;
    int t = 0;
    while (lat_count == n0 && t < 500) begin @(negedge clk); #1; t++; end
    if (lat_count == n0) chk({nm, "_latch_timeout"}, 0, 1);
  endtask
  task automatic wait_val(input string nm);
    int n0 = val_count;
    int t = 0;
    while (val_count == n0 && t < 500) begin @(negedge clk); #1; t++; end
    if (val_count == n0) chk({nm, "_valid_timeout"}, 0, 1);
    repeat (2) begin @(negedge clk); #1; end
  endtask
  task automatic wait_pulse(input int n, input logic lvl);
    int t = 0;
    while (!(pad_clk == lvl && clk_pulses == n) && t < 500) begin @(negedge clk); #1; t++; end
    if (t == 500) chk("pulse_wait_timeout", 0, 1);
  endtask
  typedef struct {
    logic [7:0] pat;
    logic [7:0] exp;
    bit per;
  } vec_t;
  vec_t v[6];
  int rel, e, n;
  initial begin
    v[0] = '{8'h00, 8'h00, 1'b0};
    v[1] = '{8'h81, 8'h81, 1'b1};
    v[2] = '{8'hFF, 8'hFF, 1'b1};
    v[3] = '{8'h00, 8'h00, 1'b1};
    v[4] = '{8'h5A, 8'h5A, 1'b1};
    v[5] = '{8'h24, 8'h24, 1'b1};
    reset = 1; enable = 1; pat = v[0].pat;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_latch", pad_latch, 0);
    chk("rst_pad_clk", pad_clk, 0);
    chk("rst_buttons", buttons, 0);
    chk("rst_valid", buttons_valid, 0);
    reset = 0; rel = cyc;
    wait_lat("first");
    chk("first_latch_delay", lat_rise - rel, 32);
    for (int k = 0; k < 6; k++) begin
      wait_val($sformatf("v%0d", k));
      chk($sformatf("v%0d_buttons", k), buttons, v[k].exp);
      chk($sformatf("v%0d_latch_to_valid", k), val_cyc - lat_rise, 68);
      chk($sformatf("v%0d_latch_width", k), lat_w, 8);
      chk($sformatf("v%0d_clk_pulses", k), clk_pulses, 7);
      chk($sformatf("v%0d_clk_width_bad", k), clk_bad, 0);
      chk($sformatf("v%0d_valid_width", k), val_w, 1);
      if (v[k].per) chk($sformatf("v%0d_poll_period", k), lat_rise - prev_rise, 100);
      if (k < 5) pat = v[k + 1].pat;
    end
    pat = 8'h3C;
    wait_lat("endrop");
    wait_pulse(4, 1'b1);
    enable = 0;
    wait_val("endrop");
    chk("endrop_buttons", buttons, 8'h3C);
    chk("endrop_clk_pulses", clk_pulses, 7);
    n = lat_count;
    repeat (200) @(negedge clk);
    #1;
    chk("no_latch_disabled", lat_count, n);
    pat = 8'h5A;
    enable = 1; e = cyc;
    wait_lat("enrise");
    chk("en_restart_next_tick", int'(lat_rise - e >= 1 && lat_rise - e <= 4), 1);
    wait_pulse(5, 1'b0);
    n = val_count;
    reset = 1;
    #1;
    chk("abort_pad_clk", pad_clk, 0);
    chk("abort_latch", pad_latch, 0);
    chk("abort_buttons", buttons, 0);
    chk("abort_valid", buttons_valid, 0);
    repeat (3) @(negedge clk);
    #1;
    pat = 8'hA5;
    reset = 0; rel = cyc;
    wait_lat("post_abort");
    chk("post_abort_latch_delay", lat_rise - rel, 32);
    chk("no_valid_on_abort", val_count, n);
    wait_val("post_abort");
    chk("post_abort_buttons", buttons, 8'hA5);
    chk("latch_clk_overlap", both_hi, 0);
    chk("partial_update", partial, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/nes_pad_reader.md
NES_PAD_READER -- requirements
Module: nes_pad_reader

Interface
REQ-001 Parameter CLK_DIV, default 300, shall set clk cycles per protocol tick (6 us at 50 MHz); legal values are >= 4.
REQ-002 Parameter POLL_TICKS, default 2778, shall set the idle ticks between polls (~16.7 ms); legal values are >= 1.
REQ-003 Port clk, input, 1 bit: the single system clock; every register shall be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port enable, input, 1 bit: while high, polls shall start automatically.
REQ-006 Port pad_data, input, 1 bit: serial data from the NES pad, active-low (0 = pressed), asynchronous to clk.
REQ-007 Port pad_latch, output, 1 bit: latch strobe to the pad.
REQ-008 Port pad_clk, output, 1 bit: shift clock to the pad.
REQ-009 Port buttons, output, 8 bits: active-high button state; bit order A, B, Select, Start, Up, Down, Left, Right for bits 0..7.
REQ-010 Port buttons_valid, output, 1 bit: one-cycle pulse when buttons is updated.

Function
REQ-011 pad_data shall pass through a 2-flop synchronizer before use; only the synchronized value shall be sampled.
REQ-012 A divider counter shall run 0..CLK_DIV-1 continuously from reset release; tick = (count == CLK_DIV-1); all state changes except DONE->IDLE shall occur only on tick.
REQ-013 States shall be IDLE, LATCH, LOW, HIGH and DONE; a 3-bit bit index i and a 16-bit-or-wider interval counter shall be kept.
REQ-014 IDLE: pad_latch=0, pad_clk=0; the interval counter shall increment on tick; when it reaches POLL_TICKS and enable=1, the block shall clear it and go to LATCH, otherwise it shall saturate at POLL_TICKS.
REQ-015 LATCH: pad_latch=1 for exactly 2 ticks; then the block shall go to LOW with i=0.
REQ-016 LOW: pad_clk=0 for 1 tick; on the ending tick, the synchronized pad_data shall be shifted into shift register bit i; if i=7 go to DONE, else go to HIGH.
REQ-017 HIGH: pad_clk=1 for 1 tick; then i shall increment and the block shall go to LOW.
REQ-018 Each transaction shall have 1 latch pulse and 7 pad_clk pulses; latch rise to DONE entry = 17 ticks = 17*CLK_DIV cycles.
REQ-019 DONE: lasts exactly one clk cycle; on entry, buttons = bitwise inverse of the shift register and buttons_valid=1; then the block shall go to IDLE with the interval counter at 0.
REQ-020 buttons shall hold its value between DONE cycles; no partial update ever.
REQ-021 enable deasserted mid-transaction shall not abort it; the transaction shall complete and the block shall then remain in IDLE until enable=1.
REQ-022 enable=1 while IDLE with the interval counter saturated shall start LATCH on the next tick.
REQ-023 pad_latch and pad_clk shall be registered outputs, never both 1 in the same cycle.

Reset
REQ-024 reset=1 shall immediately set: state IDLE, pad_latch=0, pad_clk=0, buttons=8'h00, buttons_valid=0, divider, interval counter, i and shift register all 0, synchronizer flops to 1 (released).
REQ-025 reset asserted mid-transaction shall abort it without any buttons_valid pulse; after release, the first latch shall occur POLL_TICKS ticks later if enable=1.

Verification (bench: CLK_DIV=4, POLL_TICKS=8)
REQ-026 Reset release, enable=1, pad_data=1 constant -> pad_latch high exactly 8 cycles, then 7 pad_clk pulses each high 4 cycles; buttons_valid pulses 68 cycles after latch rise; buttons=8'h00.
REQ-027 Pad model presents A and Right pressed (serial 0,1,1,1,1,1,1,0, advancing on pad_clk rise) -> buttons=8'h81 with a one-cycle buttons_valid; buttons stays 8'h81 until the next DONE.
REQ-028 All eight pressed, then all released on the next poll -> buttons=8'hFF, then 8'h00; exactly one buttons_valid pulse per transaction; consecutive latch rises are 100 cycles apart (17+8 ticks).
REQ-029 enable dropped during HIGH of bit 3 -> transaction completes, buttons_valid pulses, then no further pad_latch while enable=0; enable raised later -> pad_latch rises on the next tick.
REQ-030 reset pulsed during LOW of bit 5 -> pad_clk and pad_latch go 0 asynchronously, buttons=8'h00, no buttons_valid; after release, the first pad_latch rises 32 cycles later.
